ysyx_23060208_ifu_fetch: RTL
============================

// Module: ysyx_23060208_ifu_fetch
// PURPOSE
//  Instruction fetch unit: the reader of the PC register value. On each fetch request it
//  captures the current pc and fetches one 32-bit instruction over an AXI4-Lite read channel.
//  The channel goes to MROM/SRAM through the crossbar.
//  It hands {pc, inst} to the IDU with a valid/ready handshake.
//  Sits between the PC register, the memory bus and the decode stage.
// PARAMETERS
//  DATA_WIDTH  32  width of pc, address and instruction data
// PORTS
//  clock      in   1   single clock; all state updates on posedge
//  reset      in   1   synchronous, active-high
//  fetch_req  in   1   pulse: PC register holds a new value to fetch
//  pc         in   DW  current PC register output
//  busy       out  1   high in any state except IDLE
//  araddr     out  DW  AXI-Lite read address
//  arvalid    out  1   read address valid
//  arready    in   1   read address accepted
//  rdata      in   DW  read data
//  rresp      in   2   read response (0 = OKAY)
//  rvalid     in   1   read data valid
//  rready     out  1   read data ready
//  out_valid  out  1   fetched instruction valid to IDU
//  out_ready  in   1   IDU accepts instruction
//  out_pc     out  DW  pc of fetched instruction
//  out_inst   out  DW  fetched instruction word
//  fetch_err  out  1   access fault (IFU_ACCESS_FAULT_EN only; else tied 0)
// BEHAVIOUR
//  - Reset: state=IDLE; arvalid, rready, out_valid, busy, fetch_err = 0.
//  - Reset: araddr, out_pc, out_inst = 0.
//  - Reset mid-transaction aborts to IDLE. The bus slave is reset by the same reset.
//  - FSM: IDLE -> AR -> R -> OUT -> IDLE.
//  - IDLE: on fetch_req=1, addr_q <= {pc[DW-1:2], 2'b00}; go to AR.
//    The captured addr_q is also saved as out_pc.
//  - AR: arvalid=1, araddr=addr_q, both stable until the handshake.
//    On arvalid&&arready go to R. Earliest handshake is the first AR cycle.
//  - R: rready=1. On rvalid&&rready: out_inst <= rdata; go to OUT.
//  - OUT: out_valid=1; out_pc and out_inst held stable.
//    On out_valid&&out_ready go to IDLE. out_valid drops the next cycle.
//  - Minimum latency: fetch_req at cycle N -> out_valid at N+3.
//    This assumes arready=1 at N+1 and rvalid=1 at N+2.
//  - fetch_req outside IDLE is ignored. The PC owner must wait for busy=0.
//  - fetch_req and out_ready handshake in the same cycle:
//    the handshake wins, and the request is dropped because state is OUT.
//  - pc[1:0] != 0: the address is word-aligned as above. The low bits are ignored.
//  - Only one outstanding transaction; no request overlap, no buffering beyond one instruction.
// CONFIGURATION
//  IFU_ACCESS_FAULT_EN defined:
//   - In R, rresp!=0 still captures rdata, moves to OUT and sets fetch_err=1 alongside out_valid.
//   - fetch_err clears on the out handshake.
//  IFU_ACCESS_FAULT_EN undefined:
//   - rresp is ignored and fetch_err is constant 0.
// TESTING
//  1. Reset held 2 cycles mid-AR -> next cycle state IDLE; arvalid=0, out_valid=0, busy=0.
//  2. pc=0x0f00_0000, fetch_req pulse, arready=1, rvalid=1 with rdata=0x00000413, out_ready=1
//     -> araddr=0x0f00_0000; out_valid at +3 with out_pc=0x0f00_0000, out_inst=0x00000413.
//  3. arready held low 5 cycles -> arvalid stays 1 and araddr stays constant throughout.
//     The AR handshake happens only when arready rises.
//  4. out_ready=0 for 4 cycles in OUT -> out_valid, out_pc and out_inst stable.
//     fetch_req pulses during this window are ignored: no new arvalid.
//  5. pc=0x0f00_0006 -> araddr=0x0f00_0004 and out_pc=0x0f00_0004.
//  6. With IFU_ACCESS_FAULT_EN, rresp=2'b10 -> fetch_err=1 with out_valid; 0 after handshake.
//     Without the macro, fetch_err stays 0.

Source files
------------

// File: rtl/ysyx_23060208_ifu_fetch.sv
// Instruction fetch unit: captures the PC on a fetch request, reads one word over AXI4-Lite
// and hands {pc, inst} to decode. Optional macro IFU_ACCESS_FAULT_EN reports rresp errors.
module ysyx_23060208_ifu_fetch #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  fetch_err
);

    typedef enum logic [1:0] {
        StIdle,
        StAr,
        StR,
        StOut
    } state_e;

    state_e state_q;

    logic [DATA_WIDTH-1:0] aligned_pc;
    assign aligned_pc = {pc[DATA_WIDTH-1:2], 2'b00};

    // Low pc bits are dropped by word alignment.
    logic unused_pc_lo;
    assign unused_pc_lo = ^pc[1:0];

`ifdef IFU_ACCESS_FAULT_EN
    logic err_q;
    assign fetch_err = err_q;
`else
    logic unused_rresp;
    assign unused_rresp = ^rresp;
    assign fetch_err    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
`ifdef IFU_ACCESS_FAULT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fetch_req) begin
                        araddr  <= aligned_pc;
                        out_pc  <= aligned_pc;
                        arvalid <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= StAr;
                    end
                end
                StAr: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state_q <= StR;
                    end
                end
                StR: begin
                    if (rvalid) begin
                        out_inst  <= rdata;
                        rready    <= 1'b0;
                        out_valid <= 1'b1;
`ifdef IFU_ACCESS_FAULT_EN
                        err_q     <= (rresp != 2'b00);
`endif
                        state_q   <= StOut;
                    end
                end
                StOut: begin
                    // A fetch_req arriving here is dropped; the owner waits for busy=0.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
`ifdef IFU_ACCESS_FAULT_EN
                        err_q     <= 1'b0;
`endif
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
